// File: rtl/simon_led_player.sv
// rtl/simon_led_player.sv - turns a one-cycle play request into a timed one-hot LED flash
// Optional speaker tone generator enabled by defining SIMON_TONE_EN.
module simon_led_player #(
    parameter int ON_CYCLES     = 25_000_000,
    parameter int GAP_CYCLES    = 12_500_000,
    parameter int CNT_W         = 26,
    parameter int TONE_BASE_DIV = 28_409
) (
    input  logic       clock_signal,
    input  logic       reset_n_signal,
    input  logic       play_pulse,
    input  logic [1:0] play_color,
    output logic       busy,
    output logic [3:0] led_out,
`ifdef SIMON_TONE_EN
    output logic       tone_out,
`endif
    output logic       done_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       color_q;
    logic             on_last;

    assign on_last = (cnt == ON_LAST);

    // Requests are only looked at in IDLE, so anything arriving mid-flash is dropped.
    always_ff @(posedge clock_signal or negedge reset_n_signal) begin
        if (!reset_n_signal) begin
            state      <= IDLE;
            cnt        <= '0;
            color_q    <= 2'd0;
            busy       <= 1'b0;
            led_out    <= 4'b0000;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (play_pulse) begin
                        color_q <= play_color;
                        state   <= ON;
                        busy    <= 1'b1;
                        led_out <= 4'b0001 << play_color;
                        cnt     <= '0;
                    end
                end
                ON: begin
                    if (on_last) begin
                        cnt     <= '0;
                        led_out <= 4'b0000;
                        if (GAP_CYCLES == 0) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done_pulse <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt        <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    led_out <= 4'b0000;
                end
            endcase
        end
    end

`ifdef SIMON_TONE_EN
    // Half-period shrinks with colour index so colour 3 is the highest pitch.
    logic [31:0] tone_cnt;
    logic [31:0] tone_half;

    assign tone_half = 32'(TONE_BASE_DIV) * (32'd4 - {30'd0, color_q});

    always_ff @(posedge clock_signal or negedge reset_n_signal) begin
        if (!reset_n_signal) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (state == ON && !on_last) begin
            if (tone_cnt == tone_half - 32'd1) begin
                tone_cnt <= '0;
                tone_out <= ~tone_out;
            end else begin
                tone_cnt <= tone_cnt + 32'd1;
            end
        end else begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_simon_led_player.sv
// tb/tb_simon_led_player.sv - checks two player instances (with and without gap) against a timeline model
module tb_simon_led_player;

    logic       clk;
    logic       rst_n;
    logic       play_pulse;
    logic [1:0] play_color;

    logic       busy_a, done_a, busy_b, done_b;
    logic [3:0] led_a, led_b;
    logic       tone_a, tone_b;

    simon_led_player #(.ON_CYCLES(4), .GAP_CYCLES(2), .CNT_W(4), .TONE_BASE_DIV(1)) u_a (
        .clock_signal   (clk),
        .reset_n_signal (rst_n),
        .play_pulse     (play_pulse),
        .play_color     (play_color),
        .busy           (busy_a),
        .led_out        (led_a),
`ifdef SIMON_TONE_EN
        .tone_out       (tone_a),
`endif
        .done_pulse     (done_a)
    );

    simon_led_player #(.ON_CYCLES(4), .GAP_CYCLES(0), .CNT_W(4), .TONE_BASE_DIV(1)) u_b (
        .clock_signal   (clk),
        .reset_n_signal (rst_n),
        .play_pulse     (play_pulse),
        .play_color     (play_color),
        .busy           (busy_b),
        .led_out        (led_b),
`ifdef SIMON_TONE_EN
        .tone_out       (tone_b),
`endif
        .done_pulse     (done_b)
    );

`ifndef SIMON_TONE_EN
    assign tone_a = 1'b0;
    assign tone_b = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic       tone;
    } exp_t;

    localparam int N = 512;
    int   on_c[2]  = '{4, 4};
    int   gap_c[2] = '{2, 0};
    exp_t sched[2][N];
    int   free_at[2];
    int   cyc;
    int   passed;
    int   total;
    exp_t sb_q[$];

    task automatic schedule(input int d, input int c, input logic [1:0] col);
        int half;
        half = 4 - int'(col);
        for (int i = 1; i <= on_c[d]; i++) begin
            sched[d][c+i].led  = 4'b0001 << col;
            sched[d][c+i].busy = 1'b1;
            sched[d][c+i].tone = (((i - 1) / half) % 2) == 1;
        end
        for (int i = on_c[d] + 1; i <= on_c[d] + gap_c[d]; i++)
            sched[d][c+i].busy = 1'b1;
        sched[d][c+on_c[d]+gap_c[d]+1].done = 1'b1;
        free_at[d] = c + on_c[d] + gap_c[d] + 1;
    endtask

    task automatic check(input string tag, input exp_t obs, input exp_t exp_v, input int d);
        exp_t o, e;
        o = obs;
        e = exp_v;
`ifndef SIMON_TONE_EN
        o.tone = 1'b0;
        e.tone = 1'b0;
`endif
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s dut%0d cyc%0d: led/busy/done/tone got %b/%b/%b/%b want %b/%b/%b/%b",
                    tag, d, cyc, o.led, o.busy, o.done, o.tone, e.led, e.busy, e.done, e.tone);
    endtask

    // One clock: drive inputs for edge cyc, predict, then compare the outputs present at that edge.
    task automatic step(input string tag, input logic pulse, input logic [1:0] col, input logic rst);
        exp_t obs;
        rst_n      = rst;
        play_pulse = pulse;
        play_color = col;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                for (int k = cyc; k < N; k++) sched[d][k] = '0;
                free_at[d] = cyc;
            end else if (pulse && cyc >= free_at[d]) begin
                schedule(d, cyc, col);
            end
            sb_q.push_back(sched[d][cyc]);
        end
        #1;
        obs = '{led: led_a, busy: busy_a, done: done_a, tone: tone_a};
        check(tag, obs, sb_q.pop_front(), 0);
        obs = '{led: led_b, busy: busy_b, done: done_b, tone: tone_b};
        check(tag, obs, sb_q.pop_front(), 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        free_at = '{0, 0};
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) sched[d][k] = '0;
        rst_n      = 1'b0;
        play_pulse = 1'b0;
        play_color = 2'd0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step("reset", 1'b0, 2'd0, 1'b0);
        idle("post_reset", 2);

        step("single_c2", 1'b1, 2'd2, 1'b1);
        idle("single_c2", 9);

        step("drop_c2", 1'b1, 2'd2, 1'b1);
        idle("drop_c2", 2);
        step("drop_c2", 1'b1, 2'd0, 1'b1);
        idle("drop_c2", 7);

        step("b2b", 1'b1, 2'd2, 1'b1);
        idle("b2b", 6);
        step("b2b", 1'b1, 2'd1, 1'b1);
        idle("b2b", 9);

        for (int i = 0; i < 3; i++) step("held_c3", 1'b1, 2'd3, 1'b1);
        idle("held_c3", 8);

        step("tone_c0", 1'b1, 2'd0, 1'b1);
        idle("tone_c0", 8);

        step("abort_c3", 1'b1, 2'd3, 1'b1);
        idle("abort_c3", 1);
        step("abort_c3", 1'b1, 2'd1, 1'b0);
        step("abort_c3", 1'b0, 2'd0, 1'b0);
        idle("abort_c3", 9);

        step("after_abort", 1'b1, 2'd1, 1'b1);
        idle("after_abort", 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
